// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, next-state function and instruction opcodes.
package jtag_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  localparam int unsigned TAP_IR_W = 4;

  localparam logic [TAP_IR_W-1:0] OP_EXTEST = 4'b0000;
  localparam logic [TAP_IR_W-1:0] OP_SAMPLE = 4'b0001;
  localparam logic [TAP_IR_W-1:0] OP_IDCODE = 4'b0010;
  localparam logic [TAP_IR_W-1:0] OP_BYPASS = 4'b1111;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    case (s)
      TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    n = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        n = tms ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        n = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        n = tms ? SELECT_DR        : RUN_TEST_IDLE;
      default:          n = TEST_LOGIC_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller state register, advanced by tms on every rising tck.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst_n,
  input  logic       tms,
  output tap_state_t tap_state
);

  tap_state_t state_q;
  tap_state_t state_d;

  always_comb begin
    state_d = tap_next(state_q, tms);
  end

  always_ff @(posedge tck) begin
    if (!trst_n) state_q <= TEST_LOGIC_RESET;
    else         state_q <= state_d;
  end

  assign tap_state = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: IR and decode, BYPASS/IDCODE registers, BSC chain strobes and tdo mux.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int          IR_W   = 4,
  parameter logic [31:0] IDCODE = 32'h1000_0001
) (
  input  logic            tck,
  input  logic            trst_n,
  input  logic            tms,
  input  logic            tdi,
  output logic            tdo,
  output logic            tdo_en,
  output logic            bsc_s_i,
  input  logic            bsc_s_o,
  output logic            clock_dr,
  output logic            shift_dr,
  output logic            update_dr,
  output logic            mode,
  output logic [3:0]      tap_state
);

  localparam logic [IR_W-1:0] EXTEST_OP = IR_W'(OP_EXTEST);
  localparam logic [IR_W-1:0] SAMPLE_OP = IR_W'(OP_SAMPLE);
  localparam logic [IR_W-1:0] IDCODE_OP = IR_W'(OP_IDCODE);

  tap_state_t state;
  tap_state_t state_nxt;

  logic [IR_W-1:0] ir_q, ir_d;
  logic [IR_W-1:0] ir_sr_q, ir_sr_d;
  logic [31:0]     idreg_q, idreg_d;
  logic            byp_q, byp_d;
  logic            tdo_q, tdo_d;
  logic            tdo_en_q, tdo_en_d;
  logic            sel_chain;
  logic            sel_id;

  jtag_tap_fsm u_fsm (
    .tck       (tck),
    .trst_n    (trst_n),
    .tms       (tms),
    .tap_state (state)
  );

  assign sel_chain = (ir_q == EXTEST_OP) || (ir_q == SAMPLE_OP);
  assign sel_id    = (ir_q == IDCODE_OP);

  always_comb begin
    state_nxt = tap_next(state, tms);
    ir_d      = ir_q;
    ir_sr_d   = ir_sr_q;
    idreg_d   = idreg_q;
    byp_d     = byp_q;
    tdo_d     = tdo_q;
    tdo_en_d  = 1'b0;
    // Walking into TEST_LOGIC_RESET with tms has the same effect as trst_n.
    if (state_nxt == TEST_LOGIC_RESET) begin
      ir_d    = IDCODE_OP;
      ir_sr_d = '0;
      idreg_d = '0;
      byp_d   = 1'b0;
      tdo_d   = 1'b0;
    end else begin
      case (state)
        CAPTURE_IR: ir_sr_d = IR_W'(1);
        SHIFT_IR: begin
          ir_sr_d  = {tdi, ir_sr_q[IR_W-1:1]};
          tdo_d    = ir_sr_q[0];
          tdo_en_d = 1'b1;
        end
        UPDATE_IR: ir_d = ir_sr_q;
        CAPTURE_DR: begin
          if (sel_id)          idreg_d = IDCODE;
          else if (!sel_chain) byp_d   = 1'b0;
        end
        SHIFT_DR: begin
          tdo_en_d = 1'b1;
          if (sel_chain) begin
            tdo_d = bsc_s_o;
          end else if (sel_id) begin
            tdo_d   = idreg_q[0];
            idreg_d = {tdi, idreg_q[31:1]};
          end else begin
            tdo_d = byp_q;
            byp_d = tdi;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge tck) begin
    if (!trst_n) begin
      ir_q     <= IDCODE_OP;
      ir_sr_q  <= '0;
      idreg_q  <= '0;
      byp_q    <= 1'b0;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      ir_sr_q  <= ir_sr_d;
      idreg_q  <= idreg_d;
      byp_q    <= byp_d;
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  // Chain strobes follow the registered state directly so the chain acts in the same cycle.
  assign clock_dr  = sel_chain && ((state == CAPTURE_DR) || (state == SHIFT_DR));
  assign shift_dr  = sel_chain && (state == SHIFT_DR);
  assign update_dr = sel_chain && (state == UPDATE_DR);
  assign mode      = (ir_q == EXTEST_OP);

  assign bsc_s_i   = tdi;
  assign tdo       = tdo_q;
  assign tdo_en    = tdo_en_q;
  assign tap_state = state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Scoreboard bench for jtag_tap_ctrl with a 4-cell boundary-scan chain model.
module tb_jtag_tap_ctrl;

  localparam int K_STATE = 0;
  localparam int K_MODE  = 1;
  localparam int K_TDOEN = 2;
  localparam int K_TDO   = 3;
  localparam int K_PDATA = 4;
  localparam int K_UPD   = 5;
  localparam int K_SHF   = 6;
  localparam int K_CLK   = 7;

  typedef struct {
    int kind;
    int exp;
    int base;
  } chk_t;

  logic       tck    = 1'b0;
  logic       trst_n = 1'b1;
  logic       tms    = 1'b1;
  logic       tdi    = 1'b0;
  logic       tdo, tdo_en, bsc_s_i, bsc_s_o;
  logic       clock_dr, shift_dr, update_dr, mode;
  logic [3:0] tap_state;

  logic [3:0] chain_sr  = 4'b0000;
  logic [3:0] chain_upd = 4'b0000;
  logic [3:0] p_data_i;
  logic [3:0] p_data_o;

  chk_t chk_q[$];
  logic tdo_exp_q[$];
  bit   done = 1'b0;
  int   n_vec  = 0;
  int   n_fail = 0;
  int   upd_cnt = 0, shf_cnt = 0, clk_cnt = 0;
  int   b_upd = 0, b_shf = 0, b_clk = 0;

  always #5 tck = ~tck;

  jtag_tap_ctrl #(.IR_W(4), .IDCODE(32'h1000_0001)) dut (
    .tck       (tck),
    .trst_n    (trst_n),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .tdo_en    (tdo_en),
    .bsc_s_i   (bsc_s_i),
    .bsc_s_o   (bsc_s_o),
    .clock_dr  (clock_dr),
    .shift_dr  (shift_dr),
    .update_dr (update_dr),
    .mode      (mode),
    .tap_state (tap_state)
  );

  // Boundary-scan chain: capture pins, shift toward bit 0, update stage drives pins in mode=1.
  assign p_data_i = 4'b0110;
  assign bsc_s_o  = chain_sr[0];
  assign p_data_o = mode ? chain_upd : p_data_i;

  always @(posedge tck) begin
    if (clock_dr) chain_sr <= shift_dr ? {bsc_s_i, chain_sr[3:1]} : p_data_i;
    if (update_dr) chain_upd <= chain_sr;
  end

  function automatic string kname(input int k);
    case (k)
      K_STATE: return "tap_state";
      K_MODE:  return "mode";
      K_TDOEN: return "tdo_en";
      K_TDO:   return "tdo_hold";
      K_PDATA: return "p_data_o";
      K_UPD:   return "update_dr_cycles";
      K_SHF:   return "shift_dr_cycles";
      default: return "clock_dr_cycles";
    endcase
  endfunction

  function automatic int actual(input int k, input int base);
    case (k)
      K_STATE: return int'(tap_state);
      K_MODE:  return int'(mode);
      K_TDOEN: return int'(tdo_en);
      K_TDO:   return int'(tdo);
      K_PDATA: return int'(p_data_o);
      K_UPD:   return upd_cnt - base;
      K_SHF:   return shf_cnt - base;
      default: return clk_cnt - base;
    endcase
  endfunction

  // Monitor: samples on the falling edge, consumes tdo bits whenever tdo_en is high.
  initial begin
    chk_t c;
    logic e;
    int   a;
    while (!done) begin
      @(negedge tck);
      if (update_dr) upd_cnt++;
      if (shift_dr)  shf_cnt++;
      if (clock_dr)  clk_cnt++;
      if (tdo_en) begin
        n_vec++;
        if (tdo_exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL tdo_unexpected: tdo_en=1 tdo=%0b, required no shift output", tdo);
        end else begin
          e = tdo_exp_q.pop_front();
          if (tdo !== e) begin
            n_fail++;
            $display("FAIL tdo_bit: got %0b, required %0b (t=%0t)", tdo, e, $time);
          end
        end
      end
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        a = actual(c.kind, c.base);
        n_vec++;
        if (a != c.exp) begin
          n_fail++;
          $display("FAIL %s: got %0h, required %0h (t=%0t)", kname(c.kind), a, c.exp, $time);
        end
      end
    end
    n_vec++;
    if (tdo_exp_q.size() != 0 || chk_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d tdo bits and %0d checks left, required 0 and 0",
               tdo_exp_q.size(), chk_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic step(input logic m, input logic d);
    @(negedge tck);
    trst_n = 1'b1;
    tms    = m;
    tdi    = d;
    @(posedge tck);
  endtask

  task automatic rst_step();
    @(negedge tck);
    trst_n = 1'b0;
    tms    = 1'b0;
    tdi    = 1'b0;
    @(posedge tck);
  endtask

  task automatic expect_chk(input int kind, input int exp);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    c.base = (kind == K_UPD) ? b_upd : (kind == K_SHF) ? b_shf : b_clk;
    chk_q.push_back(c);
  endtask

  task automatic snap();
    b_upd = upd_cnt;
    b_shf = shf_cnt;
    b_clk = clk_cnt;
  endtask

  task automatic expect_no_strobes();
    expect_chk(K_UPD, 0);
    expect_chk(K_SHF, 0);
    expect_chk(K_CLK, 0);
  endtask

  // From RUN_TEST_IDLE: shift n DR bits LSB-first, update, back to RUN_TEST_IDLE.
  task automatic dr_scan(input int n, input logic [31:0] din, input logic [31:0] dout);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      tdo_exp_q.push_back(dout[i]);
      step(i == n - 1, din[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // From RUN_TEST_IDLE: load an opcode; captured 0001 always shifts out first.
  task automatic load_ir(input logic [3:0] op, input int mode_before, input int mode_after);
    logic [3:0] cap;
    cap = 4'b0001;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tdo_exp_q.push_back(cap[i]);
      step(i == 3, op[i]);
    end
    expect_chk(K_STATE, 'h9);
    expect_chk(K_MODE, mode_before);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    expect_chk(K_MODE, mode_after);
  endtask

  initial begin
    logic [31:0] idc;
    idc = 32'h1000_0001;

    rst_step();
    expect_chk(K_STATE, 'hF);
    expect_chk(K_MODE, 0);
    expect_chk(K_TDOEN, 0);
    expect_chk(K_TDO, 0);

    // IDCODE scan with a two-cycle pause halfway
    snap();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tdo_exp_q.push_back(idc[i]);
      step(i == 15, 1'($urandom_range(0, 1)));
    end
    step(1'b0, 1'b0);
    expect_chk(K_STATE, 'h3);
    expect_chk(K_TDOEN, 0);
    expect_chk(K_TDO, 0);
    step(1'b0, 1'b1);
    expect_chk(K_TDOEN, 0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 16; i < 32; i++) begin
      tdo_exp_q.push_back(idc[i]);
      step(i == 31, 1'($urandom_range(0, 1)));
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    expect_chk(K_STATE, 'hC);
    expect_no_strobes();

    // Five tms=1 from SHIFT_DR
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    tdo_exp_q.push_back(idc[0]);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    expect_chk(K_STATE, 'hF);
    expect_chk(K_TDOEN, 0);
    step(1'b0, 1'b0);

    // EXTEST through the chain, then UPDATE_DR -> RUN_TEST_IDLE -> SELECT_DR
    load_ir(4'b0000, 0, 1);
    snap();
    dr_scan(4, 32'h0000_000A, 32'h0000_0006);
    step(1'b1, 1'b0);
    expect_chk(K_STATE, 'h7);
    expect_chk(K_UPD, 1);
    expect_chk(K_SHF, 4);
    expect_chk(K_CLK, 5);
    expect_chk(K_PDATA, 'hA);
    expect_chk(K_MODE, 1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    expect_chk(K_STATE, 'hF);
    expect_chk(K_MODE, 0);
    step(1'b0, 1'b0);

    // BYPASS, explicit opcode and an undefined one
    load_ir(4'b1111, 0, 0);
    snap();
    dr_scan(8, 32'h0000_00B2, 32'h0000_0064);
    expect_no_strobes();
    load_ir(4'b0111, 0, 0);
    snap();
    dr_scan(8, 32'h0000_006D, 32'h0000_00DA);
    expect_no_strobes();

    // trst_n during SHIFT_IR after two bits of an EXTEST load
    snap();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    tdo_exp_q.push_back(1'b1);
    step(1'b0, 1'b0);
    tdo_exp_q.push_back(1'b0);
    step(1'b0, 1'b0);
    rst_step();
    expect_chk(K_STATE, 'hF);
    expect_chk(K_TDOEN, 0);
    expect_chk(K_MODE, 0);
    step(1'b0, 1'b0);
    dr_scan(8, 32'h0000_00FF, 32'h0000_0001);
    expect_no_strobes();
    expect_chk(K_MODE, 0);

    step(1'b0, 1'b0);
    done = 1'b1;
  end

endmodule
